keccak_iota_stream: RTL
=======================

Name: keccak_iota_stream

Overview:
Parametrised Keccak iota (AddRC) stage for the slice-serial permutation datapath. Accepts one state slice (SLICE_W bits) per transfer over a valid/ready stream and XORs the round-constant bit for the current slice into the lane(0,0) bit. Returns the result through a one-entry registered output with backpressure. Generalises the fixed 64-slice, free-running iota datapath to any lane width, with round latching, lane framing, flow control and range checking.

Parameters:
LANE_W, 64, slices per lane (power of 2, 1..64); slice counter wraps at LANE_W
SLICE_W, 25, bits per slice
CENTER_IDX, 12, bit position of lane(0,0) within a slice
NUM_ROUNDS, 24, number of valid round indices
ROUND_W, 5, width of round index
RC_FILE, "rc.hex", hex file with NUM_ROUNDS 64-bit constants; bit s of RC[r] applies to slice s; only bits [LANE_W-1:0] are used

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr  in  1  synchronous flush; same effect as rst
round_idx  in  ROUND_W  round of the lane being streamed; sampled on the first slice of each lane
in_valid  in  1  input slice valid
in_ready  out  1  stage can accept a slice
in_slice  in  SLICE_W  input slice
out_valid  out  1  output slice valid
out_ready  in  1  downstream accepts output
out_slice  out  SLICE_W  slice after iota
out_last  out  1  out_slice is slice LANE_W-1 of its lane
out_round  out  ROUND_W  round applied to out_slice
busy  out  1  lane partially streamed (slice counter != 0) or out_valid=1
err  out  1  sticky: a lane started with round_idx >= NUM_ROUNDS

Behaviour:
- Reset or clr (rst has priority; both synchronous): out_valid=0, out_slice=0, out_last=0, out_round=0, slice counter=0, round latch=0, err=0, FSM=IDLE. A partial lane is discarded; the next accepted slice is slice 0.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- FSM IDLE (counter 0) / STREAM (counter 1..LANE_W-1). IDLE->STREAM on accept when LANE_W>1. STREAM->IDLE on accept of slice LANE_W-1. With LANE_W=1, FSM stays IDLE.
- On accept in IDLE: round latch <= round_idx; the same cycle uses round_idx directly (bypass). In STREAM, round_idx is ignored; changes mid-lane have no effect.
- Datapath: out_slice <= in_slice with bit CENTER_IDX replaced by in_slice[CENTER_IDX] ^ RC[r][cnt]. All other bits pass unchanged. Latency is one cycle from accept to out_valid.
- out_last <= (cnt == LANE_W-1); out_round <= r. cnt increments mod LANE_W on accept only.
- Out-of-range round (r >= NUM_ROUNDS): slices pass unmodified (no XOR). err is set at lane start and holds until rst/clr.
- Output register: loads on accept. out_valid clears when out_ready && !accept. Outputs hold stable while out_valid && !out_ready.
- Simultaneous out_ready and in_valid with out_valid=1 gives full throughput of one slice per cycle with no bubble.

Optional Feature:
Macro IOTA_LFSR_RC_EN.
- Defined: no ROM or RC_FILE. RC bits are produced by an internal 8-bit LFSR (rc(t), polynomial x^8+x^6+x^5+x^4+1, seed 0x01).
  - A lane with round_idx==0 re-seeds the LFSR.
  - Each lane supplies bit rc(j+7r) to slice 2^j-1 (j=0..6, 2^j-1 < LANE_W) and 0 to all other slices. The LFSR advances 7 steps per lane.
  - A lane whose round_idx is not (previous round + 1) and not 0 also sets err.
- Undefined: ROM initialised from RC_FILE, with no sequencing requirement.

Test Plan:
1. LANE_W=64, round_idx=0, 64 all-zero slices, out_ready=1 -> slice 0 out_slice=0x0001000 (bit 12 set), slices 1..63 =0; out_last only on slice 63; out_round=0.
2. LANE_W=64, round_idx=1, all-ones slices (0x1FFFFFF) -> bit 12 cleared on slices 1, 7, 15 (RC=0x8082), all others 0x1FFFFFF.
3. LANE_W=8, round_idx=1 with round_idx changed to 5 after slice 0 -> slices 1 and 7 flipped (0x82), out_round=1 on all 8, out_last on slice 7; the next lane starts at slice 0.
4. Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_slice stable; release gives one slice per cycle with no loss or duplication.
5. round_idx=24 at lane start -> slices pass unchanged, err=1 and held across later lanes until clr.
6. rst asserted after 10 slices of a lane -> out_valid=0 and err=0 next cycle; the next accepted slice is treated as slice 0 with a freshly sampled round_idx=23 (RC bit 0 = 0, slice 0 unchanged).

Source files
------------

// File: rtl/keccak_iota_stream.sv
// keccak_iota_stream: slice-serial Keccak iota (AddRC) stage with valid/ready stream and one-entry output register
//
// Each accepted slice has bit CENTER_IDX (lane(0,0)) XORed with bit <slice> of the round constant
// of the round latched at the start of the lane. Result appears one cycle later in a registered
// output that holds under backpressure.
//
// Ports:
//   clk, rst, clr      clock, synchronous active-high reset, synchronous flush (same effect as rst)
//   round_idx          round of the lane, sampled on the first slice of each lane
//   in_valid/in_ready  input handshake, in_slice carries SLICE_W bits
//   out_valid/out_ready output handshake, out_slice/out_last/out_round describe the held result
//   busy               lane partially streamed or output pending
//   err                sticky: lane started with an invalid round
//
// Optional feature: define IOTA_LFSR_RC_EN to generate constant bits with the Keccak rc LFSR
// instead of the ROM; lanes must then be streamed in round order (0 re-seeds).
module keccak_iota_stream #(
   parameter int LANE_W     = 64,
   parameter int SLICE_W    = 25,
   parameter int CENTER_IDX = 12,
   parameter int NUM_ROUNDS = 24,
   parameter int ROUND_W    = 5,
   parameter     RC_FILE    = "rc.hex"
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [ROUND_W-1:0] round_idx,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SLICE_W-1:0] in_slice,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SLICE_W-1:0] out_slice,
   output logic               out_last,
   output logic [ROUND_W-1:0] out_round,
   output logic               busy,
   output logic               err
);
   localparam int CNT_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;
   localparam logic [ROUND_W:0] NR = (ROUND_W+1)'(NUM_ROUNDS);
   typedef enum logic {IDLE, STREAM} state_t;
   // One step of the Keccak rc LFSR, x^8+x^6+x^5+x^4+1
   function automatic logic [7:0] lfsr_step(logic [7:0] l);
      return {l[6:0], 1'b0} ^ (l[7] ? 8'h71 : 8'h00);
   endfunction
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ROUND_W-1:0] round_q, r;
   logic [SLICE_W-1:0] slice_q, slice_d;
   logic [ROUND_W-1:0] oround_q;
   logic               valid_q, last_q, err_q, err_d;
   logic               acc, first, last, in_range, rc_bit, seq_bad;
   assign in_ready = !valid_q || out_ready;
   assign acc      = in_valid && in_ready;
   assign first    = (state_q == IDLE);
   // First slice of a lane uses round_idx directly, later slices the latched round
   assign r        = first ? round_idx : round_q;
   assign last     = (cnt_q == CNT_W'(LANE_W - 1));
   assign in_range = {1'b0, r} < NR;
`ifdef IOTA_LFSR_RC_EN
   logic [7:0] lfsr_q, lfsr_d;
   logic [6:0] bits_q, bits_d, bits_sel;
   // At lane start all 7 lane bits are produced at once; slice 2^j-1 later picks bit j
   always_comb begin
      lfsr_d = (round_idx == '0) ? 8'h01 : lfsr_q;
      bits_d = '0;
      for (int j = 0; j < 7; j++) begin
         bits_d[j] = lfsr_d[0];
         lfsr_d    = lfsr_step(lfsr_d);
      end
      bits_sel = first ? bits_d : bits_q;
      rc_bit   = 1'b0;
      for (int j = 0; j < 7; j++)
         if (6'(cnt_q) == 6'((1 << j) - 1)) rc_bit = bits_sel[j];
      rc_bit  = rc_bit && in_range;
      seq_bad = (round_idx != '0) && (round_idx != round_q + ROUND_W'(1));
   end
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         lfsr_q <= 8'h01;
         bits_q <= '0;
      end else if (acc && first) begin
         lfsr_q <= lfsr_d;
         bits_q <= bits_d;
      end
   end
`else
   function automatic logic [63:0] rc_word(int rnd);
      logic [7:0]  l;
      logic [63:0] w;
      l = 8'h01;
      w = '0;
      for (int t = 0; t < 7 * rnd; t++) l = lfsr_step(l);
      for (int j = 0; j < 7; j++) begin
         w[(1 << j) - 1] = l[0];
         l = lfsr_step(l);
      end
      return w;
   endfunction
   // ROM image equals the standard Keccak constant file; an empty RC_FILE gives an all-zero table
   logic [63:0] rom [NUM_ROUNDS];
   for (genvar i = 0; i < NUM_ROUNDS; i++) begin : g_rom
      assign rom[i] = (RC_FILE == "") ? 64'd0 : rc_word(i);
   end
   assign rc_bit  = in_range && rom[r][6'(cnt_q)];
   assign seq_bad = 1'b0;
`endif
   always_comb begin
      slice_d             = in_slice;
      slice_d[CENTER_IDX] = in_slice[CENTER_IDX] ^ rc_bit;
      cnt_d               = acc ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
      state_d             = (acc && first && LANE_W > 1) ? STREAM : (acc && last) ? IDLE : state_q;
      err_d               = err_q || (acc && first && (!in_range || seq_bad));
   end
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         round_q  <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         slice_q  <= '0;
         last_q   <= 1'b0;
         oround_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         valid_q <= acc || (valid_q && !out_ready);
         if (acc && first) round_q <= round_idx;
         if (acc) begin
            slice_q  <= slice_d;
            last_q   <= last;
            oround_q <= r;
         end
      end
   end
   assign out_valid = valid_q;
   assign out_slice = slice_q;
   assign out_last  = last_q;
   assign out_round = oround_q;
   assign err       = err_q;
   assign busy      = (cnt_q != '0) || valid_q;
endmodule
